// File: rtl/bp_be_fp_wb_stage.sv
// FP writeback stage: fixed-latency shift pipeline with NaN-boxing at capture,
// flush of in-flight entries, and sticky fflags accumulation with CSR override.
module bp_be_fp_wb_stage #(
  parameter int latency_p        = 4,
  parameter int reg_data_width_p = 64,
  parameter int rd_addr_width_p  = 5
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        v_i,
  input  logic                        sp_i,
  input  logic [reg_data_width_p-1:0] data_i,
  input  logic [4:0]                  fflags_i,
  input  logic [rd_addr_width_p-1:0]  rd_addr_i,
  input  logic                        flush_i,
  input  logic                        fflags_w_v_i,
  input  logic [4:0]                  fflags_w_data_i,
  output logic                        wb_v_o,
  output logic [rd_addr_width_p-1:0]  wb_rd_addr_o,
  output logic [reg_data_width_p-1:0] wb_data_o,
  output logic [4:0]                  fflags_o,
  output logic                        busy_o
);

  localparam int last_lp = latency_p - 1;

  logic [latency_p-1:0]        v_q, v_d;
  logic [rd_addr_width_p-1:0]  rd_q   [latency_p];
  logic [rd_addr_width_p-1:0]  rd_d   [latency_p];
  logic [reg_data_width_p-1:0] data_q [latency_p];
  logic [reg_data_width_p-1:0] data_d [latency_p];
  logic [4:0]                  ff_q   [latency_p];
  logic [4:0]                  ff_d   [latency_p];
  logic [4:0]                  fflags_q, fflags_d;
  logic [reg_data_width_p-1:0] boxed;
  logic [4:0]                  retire_ff;

  // Single-precision results carry all ones above bit 31.
  always_comb begin
    boxed = data_i;
    if (sp_i) begin
      for (int i = 32; i < reg_data_width_p; i++) begin
        boxed[i] = 1'b1;
      end
    end
  end

  // Flush kills everything that would land in a stage at the next edge;
  // only the entry already in the last stage retires this cycle.
  always_comb begin
    v_d[0]    = v_i & ~flush_i;
    rd_d[0]   = rd_addr_i;
    data_d[0] = boxed;
    ff_d[0]   = fflags_i;
    for (int k = 1; k < latency_p; k++) begin
      v_d[k]    = v_q[k-1] & ~flush_i;
      rd_d[k]   = rd_q[k-1];
      data_d[k] = data_q[k-1];
      ff_d[k]   = ff_q[k-1];
    end
  end

  always_comb begin
    retire_ff = v_q[last_lp] ? ff_q[last_lp] : 5'b0;
    if (fflags_w_v_i) begin
      fflags_d = fflags_w_data_i | retire_ff;
    end else begin
      fflags_d = fflags_q | retire_ff;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q      <= '0;
      fflags_q <= '0;
    end else begin
      v_q      <= v_d;
      fflags_q <= fflags_d;
    end
  end

  // Payload needs no reset: it is qualified by the valid bits.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < latency_p; k++) begin
      rd_q[k]   <= rd_d[k];
      data_q[k] <= data_d[k];
      ff_q[k]   <= ff_d[k];
    end
  end

  assign wb_v_o       = v_q[last_lp];
  assign wb_rd_addr_o = rd_q[last_lp];
  assign wb_data_o    = data_q[last_lp];
  assign fflags_o     = fflags_q;
  assign busy_o       = |v_q;

endmodule
